vga_controller: RTL

VGA_CONTROLLER -- requirements
Module: vga_controller

---
 rtl/vga_controller.sv | 118 +++++++++++
 1 files changed

// File: rtl/vga_controller.sv
// VGA timing generator: pixel/line counters, sync generation, and a
// PIX_LATENCY-deep alignment pipeline so sync, blank and colour reach the pins together.
module vga_controller #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned PIX_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic [23:0] rgb_in,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        active,
  output logic        frame_start,
  output logic        vga_hs_n,
  output logic        vga_vs_n,
  output logic        vga_blank_n,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b
);

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned LAT     = PIX_LATENCY;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS_END  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS_END  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             raw_hs_n;
  logic             raw_vs_n;
  logic             raw_act;
  logic [LAT-1:0]   hs_pipe;
  logic [LAT-1:0]   vs_pipe;
  logic [LAT-1:0]   act_pipe;

  // Raster counters; vertical advances only on the horizontal wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
      end else begin
        h_cnt <= h_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    raw_act  = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
    raw_hs_n = !((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END));
    raw_vs_n = !((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END));
  end

  assign x           = h_cnt;
  assign y           = v_cnt;
  // Gated by reset so the counters' (0,0) reset value never reads as visible.
  assign active      = reset && raw_act;
  assign frame_start = reset && pix_en && (h_cnt == '0) && (v_cnt == '0);

  // Delay line matching the drawer's colour latency; bit 0 is the newest coordinate.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hs_pipe  <= '1;
      vs_pipe  <= '1;
      act_pipe <= '0;
    end else if (pix_en) begin
      hs_pipe  <= LAT'({hs_pipe, raw_hs_n});
      vs_pipe  <= LAT'({vs_pipe, raw_vs_n});
      act_pipe <= LAT'({act_pipe, raw_act});
    end
  end

  // Pin register: colour is sampled in the same tick its delayed timing emerges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vga_hs_n    <= 1'b1;
      vga_vs_n    <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
    end else if (pix_en) begin
      vga_hs_n    <= hs_pipe[LAT-1];
      vga_vs_n    <= vs_pipe[LAT-1];
      vga_blank_n <= act_pipe[LAT-1];
      if (act_pipe[LAT-1]) begin
        vga_r <= rgb_in[23:16];
        vga_g <= rgb_in[15:8];
        vga_b <= rgb_in[7:0];
      end else begin
        vga_r <= '0;
        vga_g <= '0;
        vga_b <= '0;
      end
    end
  end

endmodule
